// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter: default widths, requester
// indices and a small wrap-around index helper used by the round-robin search.
package wb_pkg;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int AW   = 4;

  // Requester slots on the shared register-file write port.
  typedef enum int {
    WB_ALU  = 0,
    WB_LOAD = 1,
    WB_IO   = 2
  } wb_src_e;

  // (base + step) modulo n, for base < n and step <= n.
  function automatic int wb_wrap_add(input int base, input int step, input int n);
    int s;
    s = base + step;
    if (s >= n) begin
      s = s - n;
    end
    return s;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of requester-side and register-file-side signals of the write-back
// arbiter. The arbiter uses the slave modport; producers/register file (or a
// bench) use the master modport.
//
// Handshake: requester i transfers on a rising edge where req_valid[i] and
// req_ready[i] are both 1. A requester keeps valid, rd and data stable until
// that edge; req_ready never depends on rd or data.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int NREQ = wb_pkg::NREQ,
  parameter int DW   = wb_pkg::DW,
  parameter int AW   = wb_pkg::AW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rf_regw;
  logic [AW-1:0]      rf_rd;
  logic [DW-1:0]      rf_wdata;
  logic [2**AW-1:0]   pending;

  modport master (
    output req_valid, req_rd, req_data,
    input  req_ready, rf_regw, rf_rd, rf_wdata, pending
  );

  modport slave (
    input  req_valid, req_rd, req_data,
    output req_ready, rf_regw, rf_rd, rf_wdata, pending
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Grants at most one requester per cycle, searching from
// the slot after the most recent accepted grant. The pointer only moves when
// accept_i says the grant was actually taken, so idle cycles keep the order.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  input  logic          accept_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);
  import wb_pkg::*;

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;

  // Search last+1, last+2, ... (mod N) for the first active request.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    logic          found;
    gnt_o     = '0;
    gnt_idx_o = last_q;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = wb_wrap_add(int'(last_q), k, N);
      cand_idx = IW'(cand);
      if (en_i && !found && req_i[cand_idx]) begin
        gnt_o[cand_idx] = 1'b1;
        gnt_idx_o       = cand_idx;
        found           = 1'b1;
      end
    end
  end

  // Pointer advances only on an accepted grant.
  always_comb begin
    last_d = accept_i ? gnt_idx_o : last_q;
  end

  // Pointer register; reset value N-1 gives requester 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the register file's single write port among the
// ALU, load and I/O producers. One round-robin grant per cycle is registered
// into an output stage driving rf_regw/rf_rd/rf_wdata, plus a pending-write
// one-hot mask for hazard/forwarding logic.
//
// Optional feature, macro WB_R0_ZERO_EN: a granted write with rd=0 is
// acknowledged (and advances the round-robin pointer) but never reaches the
// register file, so r0 reads as constant zero.
module wb_arbiter #(
  parameter int NREQ = wb_pkg::NREQ,
  parameter int DW   = wb_pkg::DW,
  parameter int AW   = wb_pkg::AW,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  wb_arbiter_if.slave bus
);
  import wb_pkg::*;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            arb_en;
  logic            xfer;
  logic            wr_go;
  logic [AW-1:0]   rd_arr   [NREQ];
  logic [DW-1:0]   data_arr [NREQ];
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;

  logic            regw_q, regw_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   data_q, data_d;
  logic [2**AW-1:0] pend;

  // Unpack the flat per-requester destination/data buses.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign rd_arr[i]   = bus.req_rd[i*AW +: AW];
    assign data_arr[i] = bus.req_data[i*DW +: DW];
  end

  // Grants are suppressed while reset is asserted or the arbiter is disabled.
  always_comb begin
    arb_en = enable && reset;
  end

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (reset),
    .req_i     (bus.req_valid),
    .en_i      (arb_en),
    .accept_i  (xfer),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // A grant is only ever given to a valid requester, so any grant is a transfer.
  always_comb begin
    xfer = |(gnt & bus.req_valid);
  end

  // Grant mux: route the winner's destination and data to the output stage.
  always_comb begin
    sel_rd   = rd_arr[gnt_idx];
    sel_data = data_arr[gnt_idx];
  end

  // Decide whether the transfer turns into a register-file write.
  always_comb begin
`ifdef WB_R0_ZERO_EN
    wr_go = xfer && (sel_rd != '0);
`else
    wr_go = xfer;
`endif
  end

  // Output-stage next state: pulse on a write, otherwise hold rd/data.
  always_comb begin
    regw_d = wr_go;
    rd_d   = rd_q;
    data_d = data_q;
    if (wr_go) begin
      rd_d   = sel_rd;
      data_d = sel_data;
    end
  end

  // Output-stage register; reset discards any in-flight write at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regw_q <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      regw_q <= regw_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  // Pending mask: one-hot of the destination currently being written.
  always_comb begin
    pend = '0;
    if (regw_q) begin
      pend[rd_q] = 1'b1;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rf_regw   = regw_q;
  assign bus.rf_rd     = rd_q;
  assign bus.rf_wdata  = data_q;
  assign bus.pending   = pend;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus a random phase, with a
// reference round-robin model and a write scoreboard running alongside.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int TNREQ = 3;
  localparam int TDW   = 16;
  localparam int TAW   = 4;
  localparam int W     = TAW + TDW;
  localparam int PW    = 2**TAW;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard state.
  logic [W-1:0]     exp_q[$];
  int               model_last = TNREQ - 1;
  logic             pend_xfer  = 1'b0;
  int               pend_idx   = 0;
  logic [TAW-1:0]   pend_rd    = '0;
  logic [TDW-1:0]   pend_data  = '0;
  logic [TAW-1:0]   hold_rd    = '0;
  logic [TDW-1:0]   hold_data  = '0;
  logic [TDW-1:0]   rf_model [PW];

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [TAW-1:0] rd,
                         input logic [TDW-1:0] d);
    bus.req_valid[i]           = v;
    bus.req_rd[i*TAW +: TAW]   = rd;
    bus.req_data[i*TDW +: TDW] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model: transfer bookkeeping ----------------
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        exp_q.delete();
        model_last = TNREQ - 1;
        hold_rd    = '0;
        hold_data  = '0;
        pend_xfer  = 1'b0;
      end else if (pend_xfer) begin
        model_last = pend_idx;
`ifdef WB_R0_ZERO_EN
        if (pend_rd != '0) exp_q.push_back({pend_rd, pend_data});
`else
        exp_q.push_back({pend_rd, pend_data});
`endif
        pend_xfer = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [W-1:0]      e;
    logic [PW-1:0]     exp_pend;
    logic [TNREQ-1:0]  er;
    int                gi;
    int                c;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        exp_pend = '0;
        exp_pend[e[W-1:TDW]] = 1'b1;
        tests_run++;
        if (bus.rf_regw !== 1'b1 || bus.rf_rd !== e[W-1:TDW] ||
            bus.rf_wdata !== e[TDW-1:0] || bus.pending !== exp_pend) begin
          tests_failed++;
          $display("FAIL sb_write @%0t: got regw=%b rd=%0d data=%h pend=%h, want regw=1 rd=%0d data=%h pend=%h",
                   $time, bus.rf_regw, bus.rf_rd, bus.rf_wdata, bus.pending,
                   e[W-1:TDW], e[TDW-1:0], exp_pend);
        end
        hold_rd   = e[W-1:TDW];
        hold_data = e[TDW-1:0];
      end else begin
        tests_run++;
        if (bus.rf_regw !== 1'b0 || bus.pending !== '0 ||
            bus.rf_rd !== hold_rd || bus.rf_wdata !== hold_data) begin
          tests_failed++;
          $display("FAIL sb_idle @%0t: got regw=%b rd=%0d data=%h pend=%h, want regw=0 rd=%0d data=%h pend=0",
                   $time, bus.rf_regw, bus.rf_rd, bus.rf_wdata, bus.pending, hold_rd, hold_data);
        end
      end
      if (bus.rf_regw === 1'b1) rf_model[bus.rf_rd] = bus.rf_wdata;

      er = '0;
      gi = -1;
      if (reset === 1'b1 && enable === 1'b1) begin
        for (int k = 1; k <= TNREQ; k++) begin
          c = (model_last + k) % TNREQ;
          if (gi < 0 && bus.req_valid[c] === 1'b1) gi = c;
        end
      end
      if (gi >= 0) er[gi] = 1'b1;
      tests_run++;
      if (bus.req_ready !== er) begin
        tests_failed++;
        $display("FAIL sb_ready @%0t: got %b, want %b", $time, bus.req_ready, er);
      end
      if (gi >= 0) begin
        pend_xfer = 1'b1;
        pend_idx  = gi;
        pend_rd   = bus.req_rd[gi*TAW +: TAW];
        pend_data = bus.req_data[gi*TDW +: TDW];
      end else begin
        pend_xfer = 1'b0;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mid();
    set_req(0, 1'b1, 4'd1, 16'h0101);
    set_req(1, 1'b1, 4'd2, 16'h0202);
    set_req(2, 1'b1, 4'd3, 16'h0303);
    enable = 1'b1;
    #1;
    tests_run++;
    if (bus.req_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b, want 000", bus.req_ready);
    end
    tests_run++;
    if (bus.rf_regw !== 1'b0 || bus.rf_rd !== 4'd0 || bus.rf_wdata !== 16'h0 || bus.pending !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got regw=%b rd=%0d data=%h pend=%h, want all 0",
               bus.rf_regw, bus.rf_rd, bus.rf_wdata, bus.pending);
    end
    tick();
    bus.req_valid = '0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    tick();
    set_req(int'(WB_ALU), 1'b1, 4'd3, 16'h1234);
    mid();
    tests_run++;
    if (bus.req_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL single_ready: got %b, want 001", bus.req_ready);
    end
    tick();
    set_req(int'(WB_ALU), 1'b0, 4'd0, 16'h0);
    mid();
    tests_run++;
    if (bus.rf_regw !== 1'b1 || bus.rf_rd !== 4'd3 || bus.rf_wdata !== 16'h1234 || bus.pending !== 16'h0008) begin
      tests_failed++;
      $display("FAIL single_write: got regw=%b rd=%0d data=%h pend=%h, want 1 3 1234 0008",
               bus.rf_regw, bus.rf_rd, bus.rf_wdata, bus.pending);
    end
  endtask

  task automatic test_round_robin();
    logic [TNREQ-1:0] exp_gnt [6];
    logic [TNREQ-1:0] got;
    int regw_cnt;
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    // Make requester 2 the most recent winner so the cycle starts at 0.
    tick();
    set_req(int'(WB_IO), 1'b1, 4'd7, 16'($urandom_range(0, 65535)));
    mid();
    tick();
    set_req(int'(WB_IO), 1'b0, 4'd0, 16'h0);
    mid();
    tick();
    for (int i = 0; i < TNREQ; i++) set_req(i, 1'b1, TAW'(i + 1), 16'($urandom_range(0, 65535)));
    regw_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      mid();
      got = bus.req_ready;
      tests_run++;
      if (got !== exp_gnt[i]) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: got %b, want %b", i, got, exp_gnt[i]);
      end
      if (i >= 1 && bus.rf_regw === 1'b1) regw_cnt++;
    end
    tick();
    bus.req_valid = '0;
    mid();
    if (bus.rf_regw === 1'b1) regw_cnt++;
    tests_run++;
    if (regw_cnt != 6) begin
      tests_failed++;
      $display("FAIL rr_regw_count: got %0d, want 6", regw_cnt);
    end
  endtask

  task automatic test_same_dest();
    tick();
    set_req(int'(WB_ALU),  1'b1, 4'd5, 16'hAAAA);
    set_req(int'(WB_LOAD), 1'b1, 4'd5, 16'h5555);
    mid();
    tests_run++;
    if (bus.req_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL same_first_grant: got %b, want 001", bus.req_ready);
    end
    tick();
    set_req(int'(WB_ALU), 1'b0, 4'd0, 16'h0);
    mid();
    tests_run++;
    if (bus.rf_regw !== 1'b1 || bus.rf_rd !== 4'd5 || bus.rf_wdata !== 16'hAAAA || bus.req_ready !== 3'b010) begin
      tests_failed++;
      $display("FAIL same_first_write: got regw=%b rd=%0d data=%h ready=%b, want 1 5 aaaa 010",
               bus.rf_regw, bus.rf_rd, bus.rf_wdata, bus.req_ready);
    end
    tick();
    set_req(int'(WB_LOAD), 1'b0, 4'd0, 16'h0);
    mid();
    tests_run++;
    if (bus.rf_regw !== 1'b1 || bus.rf_wdata !== 16'h5555 || rf_model[5] !== 16'h5555) begin
      tests_failed++;
      $display("FAIL same_final: got regw=%b data=%h r5=%h, want 1 5555 5555",
               bus.rf_regw, bus.rf_wdata, rf_model[5]);
    end
  endtask

  task automatic test_enable();
    tick();
    for (int i = 0; i < TNREQ; i++) set_req(i, 1'b1, TAW'(i + 1), 16'($urandom_range(0, 65535)));
    mid();
    tests_run++;
    if (bus.req_ready !== 3'b100) begin
      tests_failed++;
      $display("FAIL en_first_grant: got %b, want 100", bus.req_ready);
    end
    tick();
    enable = 1'b0;
    mid();
    tests_run++;
    if (bus.rf_regw !== 1'b1 || bus.rf_rd !== 4'd3 || bus.req_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL en_inflight: got regw=%b rd=%0d ready=%b, want 1 3 000",
               bus.rf_regw, bus.rf_rd, bus.req_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      mid();
      tests_run++;
      if (bus.rf_regw !== 1'b0 || bus.req_ready !== 3'b000) begin
        tests_failed++;
        $display("FAIL en_blocked[%0d]: got regw=%b ready=%b, want 0 000", i, bus.rf_regw, bus.req_ready);
      end
    end
    tick();
    enable = 1'b1;
    mid();
    tests_run++;
    if (bus.req_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL en_resume: got %b, want 001", bus.req_ready);
    end
    for (int i = 0; i < TNREQ; i++) begin
      tick();
      set_req(i, 1'b0, 4'd0, 16'h0);
      mid();
    end
  endtask

  task automatic test_async_reset();
    tick();
    set_req(int'(WB_ALU), 1'b1, 4'd9, 16'hBEEF);
    mid();
    tick();
    #1;
    tests_run++;
    if (bus.rf_regw !== 1'b1 || bus.rf_rd !== 4'd9) begin
      tests_failed++;
      $display("FAIL arst_before: got regw=%b rd=%0d, want 1 9", bus.rf_regw, bus.rf_rd);
    end
    #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.rf_regw !== 1'b0 || bus.rf_rd !== 4'd0 || bus.rf_wdata !== 16'h0 ||
        bus.pending !== 16'h0 || bus.req_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL arst_clear: got regw=%b rd=%0d data=%h pend=%h ready=%b, want all 0",
               bus.rf_regw, bus.rf_rd, bus.rf_wdata, bus.pending, bus.req_ready);
    end
    set_req(int'(WB_ALU),  1'b1, 4'd4, 16'h1111);
    set_req(int'(WB_LOAD), 1'b1, 4'd6, 16'h2222);
    tick();
    reset = 1'b1;
    mid();
    tests_run++;
    if (bus.req_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL arst_priority: got %b, want 001", bus.req_ready);
    end
    tick();
    set_req(int'(WB_ALU), 1'b0, 4'd0, 16'h0);
    mid();
    tick();
    set_req(int'(WB_LOAD), 1'b0, 4'd0, 16'h0);
    mid();
  endtask

  task automatic test_r0();
    tick();
    set_req(int'(WB_IO), 1'b1, 4'd0, 16'hFFFF);
    mid();
    tests_run++;
    if (bus.req_ready !== 3'b100) begin
      tests_failed++;
      $display("FAIL r0_ready: got %b, want 100", bus.req_ready);
    end
    tick();
    set_req(int'(WB_IO), 1'b0, 4'd0, 16'h0);
    mid();
    tests_run++;
`ifdef WB_R0_ZERO_EN
    if (bus.rf_regw !== 1'b0 || bus.pending !== 16'h0) begin
      tests_failed++;
      $display("FAIL r0_write: got regw=%b pend=%h, want 0 0000", bus.rf_regw, bus.pending);
    end
`else
    if (bus.rf_regw !== 1'b1 || bus.rf_rd !== 4'd0 || bus.rf_wdata !== 16'hFFFF || bus.pending !== 16'h0001) begin
      tests_failed++;
      $display("FAIL r0_write: got regw=%b rd=%0d data=%h pend=%h, want 1 0 ffff 0001",
               bus.rf_regw, bus.rf_rd, bus.rf_wdata, bus.pending);
    end
`endif
  endtask

  task automatic test_random();
    logic [TNREQ-1:0] rdy;
    for (int cyc = 0; cyc < 60; cyc++) begin
      mid();
      rdy = bus.req_ready;
      tick();
      enable = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < TNREQ; i++) begin
        if (bus.req_valid[i] !== 1'b1 || rdy[i]) begin
          if ($urandom_range(0, 3) != 0)
            set_req(i, 1'b1, TAW'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
          else
            set_req(i, 1'b0, 4'd0, 16'h0);
        end
      end
    end
    // Drain outstanding requests, retiring each one after its transfer.
    enable = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      mid();
      rdy = bus.req_ready;
      tick();
      for (int i = 0; i < TNREQ; i++) if (rdy[i]) set_req(i, 1'b0, 4'd0, 16'h0);
    end
    mid();
    tests_run++;
    if (bus.req_valid !== 3'b000) begin
      tests_failed++;
      $display("FAIL rand_drain: got valid=%b, want 000", bus.req_valid);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset         = 1'b0;
    enable        = 1'b0;
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    for (int i = 0; i < PW; i++) rf_model[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_same_dest();
    test_enable();
    test_async_reset();
    test_r0();
    test_random();
    tick();
    mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d outstanding writes, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sharing the register file's single write port among three producers: ALU result, load data, I/O input. It grants at most one request per cycle by round robin. The granted write is registered into an output stage that drives the register file's write enable, destination and data. It also publishes a pending-write mask for hazard and forwarding logic.

## Interface
- NREQ, 3, number of requesters; index 0 ALU, 1 load, 2 I/O.
- DW, 16, data width.
- AW, 4, register address width (16 registers).
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- enable  in  1  global enable; low blocks new grants.
- req_valid  in  NREQ  per-requester write request.
- req_rd  in  NREQ*AW  per-requester destination, requester i at bits [i*AW +: AW].
- req_data  in  NREQ*DW  per-requester write data, same packing.
- req_ready  out  NREQ  per-requester grant (combinational, one-hot or zero).
- rf_regw  out  1  register-file write enable.
- rf_rd  out  AW  register-file destination.
- rf_wdata  out  DW  register-file write data.
- pending  out  2**AW  one-hot of rf_rd when rf_regw=1, else 0.

## Operation
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both 1 on a rising edge.
  - A requester holds valid, rd and data stable until the transfer.
  - Valid must not drop before the transfer.
- req_ready is 0 for all requesters while reset=0 or enable=0.
- Otherwise exactly one valid requester gets ready=1, chosen by round robin:
  - Search starts at index last+1 and wraps modulo NREQ.
  - last is the index of the most recent transfer.
- last updates only on a transfer. With no transfer, last holds and the priority order is unchanged.
- Output stage loads on every rising edge:
  - rf_regw <= transfer occurred.
  - rf_rd, rf_wdata <= granted requester's rd and data on a transfer; otherwise hold their previous values.
- Output stage never stalls, since the register file accepts one write per cycle. rf_regw is therefore a one-cycle pulse per transfer.
- Two requesters targeting the same register in the same cycle: both are served in consecutive cycles in grant order. The later grant wins the register contents.
- enable dropping mid-stream: no new grants. An already-loaded output-stage write still issues in the next cycle.
- Reset values: rf_regw=0, rf_rd=0, rf_wdata=0, pending=0, last=NREQ-1 (requester 0 has first priority).
- Reset asserted mid-operation: an in-flight write is discarded and no register-file write occurs.

## Timing
- Latency: a transfer on edge N gives rf_regw=1 with rf_rd and rf_wdata valid from edge N until edge N+1.
- The register file commits the write on the falling edge inside that window.
- Throughput: one write per cycle sustained.
- Fairness: with all NREQ requesters continuously valid, grants cycle 0,1,2,0,… Worst-case wait is NREQ-1 cycles.
- req_ready depends combinationally on req_valid, enable, reset and last. It has no path from req_rd or req_data.
- pending is a combinational decode of the registered rf_regw and rf_rd.

## Configuration
- WB_R0_ZERO_EN defined:
  - A request with rd=0 is still granted and acknowledged, and still advances last.
  - It produces no write: rf_regw stays 0 and pending stays 0. rf_rd and rf_wdata hold.
  - r0 therefore reads as constant zero.
- WB_R0_ZERO_EN undefined: r0 is an ordinary register and writes to it issue normally.

## Structure
- Shared package wb_pkg holds:
  - Requester index constants WB_ALU=0, WB_LOAD=1, WB_IO=2.
  - Default widths DW=16, AW=4, NREQ=3.
- Sub-module rr_arbiter (parameter N):
  - Inputs: request vector, enable.
  - Outputs: one-hot grant, encoded grant index.
  - Holds the last-grant pointer internally and updates it only on an accept input.
- wb_arbiter instantiates rr_arbiter, the grant mux for rd and data, the output stage and the pending decode.

## Test plan
- Reset then single request: release reset; ALU requests rd=3, data=0x1234 → ready[0]=1 that cycle; next cycle rf_regw=1, rf_rd=3, rf_wdata=0x1234, pending=0x0008.
- All three requesters valid for 6 cycles (rd 1,2,3) → grants 0,1,2,0,1,2; rf_regw high 6 consecutive cycles.
- Same-destination conflict: ALU rd=5 data=0xAAAA and load rd=5 data=0x5555 both valid → ALU written first, then load; register 5 ends at 0x5555.
- enable low with all requesters valid for 3 cycles → req_ready=0, rf_regw=0. Re-enable → grant resumes at last+1.
- Async reset asserted mid-stream with rf_regw=1 → rf_regw, rf_rd, rf_wdata and pending go to 0 immediately, without a clock edge. After release, requester 0 has priority.
- WB_R0_ZERO_EN defined: I/O request rd=0 data=0xFFFF → ready[2]=1, rf_regw stays 0, pending=0. Undefined: rf_regw=1, rf_rd=0.
